// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: combinational hit path in front
// of a word-wide memory, with a two-state line-fill engine on misses.
module icache_dm #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcF,
  input  logic        invalidate,
  output logic [31:0] instrF,
  output logic        stallF,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int OFFW  = $clog2(WORDS);
  localparam int IDXW  = $clog2(LINES);
  localparam int TAGW  = 32 - IDXW - OFFW - 2;
  localparam int BASEW = TAGW + IDXW;

  typedef enum logic {IDLE, FILL} state_t;

  // state is the observable FSM state for checkers
  state_t state, state_nx;

  logic [OFFW-1:0]  word, cnt, cnt_nx;
  logic [IDXW-1:0]  idx, fill_idx;
  logic [TAGW-1:0]  tag, fill_tag;
  logic [BASEW-1:0] fill_base, fill_base_nx;
  logic             hit, beat, last, hit_inc, miss_inc;
  logic             unused_pc_bits;

  logic [31:0]      data_arr [LINES*WORDS];
  logic [TAGW-1:0]  tag_arr  [LINES];
  logic [LINES-1:0] valid;

  assign word     = pcF[OFFW+1:2];
  assign idx      = pcF[IDXW+OFFW+1:OFFW+2];
  assign tag      = pcF[31:IDXW+OFFW+2];
  assign fill_idx = fill_base[IDXW-1:0];
  assign fill_tag = fill_base[BASEW-1:IDXW];
  assign unused_pc_bits = ^pcF[1:0];

  assign hit    = (state == IDLE) && valid[idx] && (tag_arr[idx] == tag);
  assign stallF = !hit;
  assign instrF = hit ? data_arr[{idx, word}] : 32'h0;

  // Fill handshake: mem_req stays high with a stable mem_addr until a cycle
  // with mem_ready=1; that cycle transfers one beat and mem_rdata is taken
  // on the same edge. A request is never withdrawn except by invalidate/reset.
  assign mem_req  = (state == FILL);
  assign mem_addr = mem_req ? {fill_base, cnt, 2'b00} : 32'h0;
  assign beat     = mem_req && mem_ready;
  assign last     = beat && (cnt == OFFW'(WORDS - 1));

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    fill_base_nx = fill_base;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          hit_inc = 1'b1;
        end else if (!invalidate) begin
          fill_base_nx = {tag, idx};
          cnt_nx       = '0;
          miss_inc     = 1'b1;
          state_nx     = FILL;
        end
      end
      FILL: begin
        if (invalidate) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (beat) begin
          cnt_nx = cnt + 1'b1;
          if (last) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      fill_base  <= '0;
      valid      <= '0;
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      fill_base <= fill_base_nx;
      if (hit_inc)  hit_count  <= hit_count + 32'h1;
      if (miss_inc) miss_count <= miss_count + 32'h1;
      // invalidate wins over the valid set of a completing fill
      if (invalidate)  valid           <= '0;
      else if (last)   valid[fill_idx] <= 1'b1;
    end
  end

  // Line storage carries no reset; valid bits alone qualify its contents.
  always_ff @(posedge clk) begin
    if (beat && !invalidate) data_arr[{fill_idx, cnt}] <= mem_rdata;
    if (last && !invalidate) tag_arr[fill_idx]         <= fill_tag;
  end

endmodule
